seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Six-digit time-multiplexed 7-segment scan controller with frame-aligned display updates.
// Define SEG_LZ_BLANK_EN to enable leading-zero suppression.
module seg_scan_ctrl #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned SCAN_FREQ = 1000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        disp_en,
    input  logic [5:0]  dig_en,
    input  logic [23:0] upd_data,
    input  logic        upd_valid,
    output logic        upd_ready,
    output logic [5:0]  seg_sel,
    output logic [3:0]  bin_num,
    output logic        seg_blank,
    output logic        frame_done
);

    localparam int unsigned SCAN_DIV = CLK_FREQ / SCAN_FREQ;
    localparam int unsigned CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_ON
    } state_t;

    state_t           r_state, w_state_d;
    logic [2:0]       r_idx, w_idx_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [23:0]      r_disp, w_disp_d;
    logic [23:0]      r_pend, w_pend_d;
    logic             r_pend_full, w_pend_full_d;
    logic             r_lit, w_lit_d;
    logic [5:0]       r_seg_sel, w_seg_sel_d;
    logic [3:0]       r_bin_num, w_bin_num_d;
    logic             r_seg_blank, w_seg_blank_d;
    logic             r_frame_done, w_frame_done_d;
    logic             w_swap;
    logic [5:0]       w_lz;

`ifdef SEG_LZ_BLANK_EN
    logic [5:0] r_lz_blank;

    // Bit i set when nibbles 5..i are all zero; digit 0 is never suppressed.
    function automatic logic [5:0] f_lz_mask(input logic [23:0] d);
        logic [5:0] m;
        logic       z;
        m = 6'b0;
        z = 1'b1;
        for (int i = 5; i >= 1; i--) begin
            z    = z & (d[4*i +: 4] == 4'h0);
            m[i] = z;
        end
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lz_blank <= 6'b111110;
        end else if (w_swap) begin
            r_lz_blank <= f_lz_mask(r_pend);
        end
    end

    assign w_lz = r_lz_blank;
`else
    assign w_lz = 6'b0;
`endif

    always_comb begin
        w_state_d      = r_state;
        w_idx_d        = r_idx;
        w_cnt_d        = r_cnt;
        w_disp_d       = r_disp;
        w_pend_d       = r_pend;
        w_pend_full_d  = r_pend_full;
        w_lit_d        = r_lit;
        w_frame_done_d = 1'b0;
        w_swap         = 1'b0;

        if (upd_valid && !r_pend_full) begin
            w_pend_d      = upd_data;
            w_pend_full_d = 1'b1;
        end

        if (!disp_en) begin
            w_state_d = S_IDLE;
            w_idx_d   = 3'd0;
            w_cnt_d   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_state_d = S_BLANK;
                    w_idx_d   = 3'd0;
                    w_cnt_d   = '0;
                    w_swap    = r_pend_full;
                end
                S_BLANK: begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                    if (r_cnt == BLANK_LAST) begin
                        w_state_d = S_ON;
                        // Digit enable is latched once per slot so a mid-slot change cannot flicker.
                        w_lit_d   = dig_en[r_idx] & ~w_lz[r_idx];
                    end
                end
                S_ON: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_d   = '0;
                        w_state_d = S_BLANK;
                        if (r_idx == 3'd5) begin
                            w_idx_d        = 3'd0;
                            w_frame_done_d = 1'b1;
                            w_swap         = r_pend_full;
                        end else begin
                            w_idx_d = r_idx + 3'd1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_state_d = S_IDLE;
                    w_idx_d   = 3'd0;
                    w_cnt_d   = '0;
                end
            endcase
        end

        if (w_swap) begin
            w_disp_d      = r_pend;
            w_pend_full_d = 1'b0;
        end

        // Outputs are derived from the next state so they line up with the registered FSM.
        w_seg_sel_d   = 6'b111111;
        w_seg_blank_d = 1'b1;
        w_bin_num_d   = 4'h0;
        if (w_state_d != S_IDLE) begin
            w_bin_num_d = 4'(w_disp_d >> {w_idx_d, 2'b00});
        end
        if (w_state_d == S_ON) begin
            w_seg_blank_d = ~w_lit_d;
            if (w_lit_d) begin
                w_seg_sel_d = ~(6'b000001 << w_idx_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 3'd0;
            r_cnt        <= '0;
            r_disp       <= 24'h0;
            r_pend       <= 24'h0;
            r_pend_full  <= 1'b0;
            r_lit        <= 1'b0;
            r_seg_sel    <= 6'b111111;
            r_bin_num    <= 4'h0;
            r_seg_blank  <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_idx        <= w_idx_d;
            r_cnt        <= w_cnt_d;
            r_disp       <= w_disp_d;
            r_pend       <= w_pend_d;
            r_pend_full  <= w_pend_full_d;
            r_lit        <= w_lit_d;
            r_seg_sel    <= w_seg_sel_d;
            r_bin_num    <= w_bin_num_d;
            r_seg_blank  <= w_seg_blank_d;
            r_frame_done <= w_frame_done_d;
        end
    end

    assign upd_ready  = ~r_pend_full;
    assign seg_sel    = r_seg_sel;
    assign bin_num    = r_bin_num;
    assign seg_blank  = r_seg_blank;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-based reference model compared every cycle, plus directed
// literal checks; works with or without SEG_LZ_BLANK_EN.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int SD    = 10;
    localparam int BC    = 2;
    localparam int FRAME = 6 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        disp_en = 1'b0;
    logic [5:0]  dig_en = 6'h3F;
    logic [23:0] upd_data = 24'h0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [5:0]  seg_sel;
    logic [3:0]  bin_num;
    logic        seg_blank;
    logic        frame_done;

    seg_scan_ctrl #(
        .CLK_FREQ (1000),
        .SCAN_FREQ(100),
        .BLANK_CYC(BC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .disp_en   (disp_en),
        .dig_en    (dig_en),
        .upd_data  (upd_data),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .seg_sel   (seg_sel),
        .bin_num   (bin_num),
        .seg_blank (seg_blank),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Reference model: position within the frame is a plain cycle count since enable.
    bit          m_on;
    int          m_t;
    logic [23:0] m_disp, m_pend;
    bit          m_full, m_lit, m_fd;
    logic [5:0]  m_lz;

    function automatic logic [5:0] lz_of(input logic [23:0] d);
        logic [5:0] m;
        int top;
        m = 6'b0;
        top = 0;
`ifdef SEG_LZ_BLANK_EN
        for (int i = 0; i < 6; i++) if (d[i*4 +: 4] != 4'h0) top = i;
        for (int i = 0; i < 6; i++) m[i] = (i > top);
`endif
        return m;
    endfunction

    task automatic model_reset();
        m_on = 0; m_t = 0; m_disp = 0; m_pend = 0; m_full = 0; m_lit = 0; m_fd = 0;
        m_lz = lz_of(24'h0);
    endtask

    task automatic model_step();
        bit acc, swp;
        acc = upd_valid && !m_full;
        swp = 0;
        m_fd = 0;
        if (!disp_en) begin
            m_on = 0; m_t = 0;
        end else if (!m_on) begin
            m_on = 1; m_t = 0; swp = m_full;
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0; m_fd = 1; swp = m_full;
            end
        end
        if (acc) begin m_pend = upd_data; m_full = 1; end
        if (swp) begin m_disp = m_pend; m_full = 0; m_lz = lz_of(m_disp); end
        if (m_on && (m_t % SD) == BC) m_lit = dig_en[m_t / SD] && !m_lz[m_t / SD];
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int idx;
                logic [5:0] e_sel;
                logic [3:0] e_bin;
                logic e_blank;
                idx = m_t / SD;
                e_sel = 6'h3F; e_blank = 1'b1; e_bin = 4'h0;
                if (m_on) begin
                    e_bin = m_disp[idx*4 +: 4];
                    if ((m_t % SD) >= BC && m_lit) begin
                        e_sel = 6'h3F & ~(6'd1 << idx);
                        e_blank = 1'b0;
                    end
                end
                chk("seg_sel", {18'h0, seg_sel}, {18'h0, e_sel});
                chk("bin_num", {20'h0, bin_num}, {20'h0, e_bin});
                chk("seg_blank", {23'h0, seg_blank}, {23'h0, e_blank});
                chk("frame_done", {23'h0, frame_done}, {23'h0, m_fd});
                chk("upd_ready", {23'h0, upd_ready}, {23'h0, !m_full});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_t(input int target);
        for (int i = 0; i < 200 && !(m_on && m_t == target); i++) tick();
        if (!(m_on && m_t == target)) begin
            n_checks++; n_errors++;
            $display("FAIL sync: frame position %0d not reached, at %0d", target, m_t);
        end
    endtask

    task automatic frame_lit(output logic [5:0] lit);
        lit = 6'h0;
        wait_t(0);
        for (int i = 0; i < FRAME; i++) begin
            lit |= ~seg_sel;
            tick();
        end
    endtask

    logic [5:0] lit;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("reset seg_sel", {18'h0, seg_sel}, 24'h3F);
        chk("reset seg_blank", {23'h0, seg_blank}, 24'h1);
        chk("reset bin_num", {20'h0, bin_num}, 24'h0);
        chk("reset upd_ready", {23'h0, upd_ready}, 24'h1);
        repeat (2) tick();
        chk_en = 1'b1;
        rst_n = 1'b1;
        tick();

        // Load 123456 during frame 0, visible from frame 1.
        disp_en = 1'b1;
        tick();
        chk("f0 t0 sel", {18'h0, seg_sel}, 24'h3F);
        upd_data = 24'h123456; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        chk("ready after load", {23'h0, upd_ready}, 24'h0);
        wait_t(FRAME - 1);
`ifdef SEG_LZ_BLANK_EN
        chk("f0 digit5 sel", {18'h0, seg_sel}, 24'h3F);
`else
        chk("f0 digit5 sel", {18'h0, seg_sel}, 24'h1F);
`endif
        chk("f0 digit5 bin", {20'h0, bin_num}, 24'h0);
        tick();
        chk("f1 frame_done", {23'h0, frame_done}, 24'h1);
        chk("f1 t0 sel", {18'h0, seg_sel}, 24'h3F);
        chk("f1 t0 bin preload", {20'h0, bin_num}, 24'h6);
        chk("ready after swap", {23'h0, upd_ready}, 24'h1);
        tick(); tick();
        chk("f1 digit0 sel", {18'h0, seg_sel}, 24'h3E);
        chk("f1 digit0 bin", {20'h0, bin_num}, 24'h6);
        chk("f1 digit0 blank", {23'h0, seg_blank}, 24'h0);
        wait_t(52);
        chk("f1 digit5 sel", {18'h0, seg_sel}, 24'h1F);
        chk("f1 digit5 bin", {20'h0, bin_num}, 24'h1);

        // Back-pressure: A accepted, B held until the cycle after the swap.
        wait_t(4);
        upd_data = 24'hAAAAAA; upd_valid = 1'b1;
        tick();
        chk("A accepted", {23'h0, upd_ready}, 24'h0);
        upd_data = 24'hBBBBBB;
        wait_t(FRAME - 1);
        tick();
        chk("ready after A swap", {23'h0, upd_ready}, 24'h1);
        chk("A shown", {20'h0, bin_num}, 24'hA);
        tick();
        upd_valid = 1'b0;
        chk("B accepted", {23'h0, upd_ready}, 24'h0);
        wait_t(FRAME - 1);
        tick();
        chk("B shown", {20'h0, bin_num}, 24'hB);

        // Digit mask 000011 over a full frame.
        dig_en = 6'b000011;
        frame_lit(lit);
        chk("mask lit digits", {18'h0, lit}, 24'h03);
        chk("mask frame length", {23'h0, frame_done}, 24'h1);
        dig_en = 6'h3F;

        // disp_en drop during digit 3 ON, then restart from digit 0.
        wait_t(33);
        disp_en = 1'b0;
        tick();
        chk("dark after drop", {18'h0, seg_sel}, 24'h3F);
        repeat (3) tick();
        chk("dark held", {18'h0, seg_sel}, 24'h3F);
        disp_en = 1'b1;
        tick();
        chk("restart blank 0", {18'h0, seg_sel}, 24'h3F);
        tick();
        chk("restart blank 1", {18'h0, seg_sel}, 24'h3F);
        tick();
        chk("restart digit0", {18'h0, seg_sel}, 24'h3E);

        // Leading-zero behaviour.
        upd_data = 24'h000045; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        frame_lit(lit);
`ifdef SEG_LZ_BLANK_EN
        chk("lz 000045", {18'h0, lit}, 24'h03);
`else
        chk("lz 000045", {18'h0, lit}, 24'h3F);
`endif
        upd_data = 24'h000000; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        frame_lit(lit);
`ifdef SEG_LZ_BLANK_EN
        chk("lz 000000", {18'h0, lit}, 24'h01);
`else
        chk("lz 000000", {18'h0, lit}, 24'h3F);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            upd_valid = ($urandom_range(0, 3) == 0);
            upd_data = 24'($urandom);
            if ($urandom_range(0, 199) == 0) disp_en = ~disp_en;
            if ($urandom_range(0, 99) == 0) dig_en = 6'($urandom);
            tick();
        end

        // Asynchronous reset mid-slot discards a pending word.
        disp_en = 1'b1; dig_en = 6'h3F;
        upd_data = 24'h987654; upd_valid = 1'b1;
        repeat (SD + 3) tick();
        upd_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async reset seg_sel", {18'h0, seg_sel}, 24'h3F);
        chk("async reset seg_blank", {23'h0, seg_blank}, 24'h1);
        chk("async reset bin_num", {20'h0, bin_num}, 24'h0);
        chk("async reset upd_ready", {23'h0, upd_ready}, 24'h1);
        tick();
        rst_n = 1'b1;
        repeat (FRAME + 20) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
